mux_n1_rr_reg: RTL

// - Parametrised N:1 data multiplexer with a registered output and valid/ready handshakes.
// - Selects either a fixed channel (sel_in) or the next valid channel in round-robin order.
// - Merges several producer streams onto one consumer.
// - Output holds stable under backpressure.

---
 rtl/mux_n1_rr_reg_pkg.sv | 15 +
 rtl/mux_n1_rr_reg_rr_pick.sv | 42 ++++
 rtl/mux_n1_rr_reg.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mux_n1_rr_reg_pkg.sv
// -----------------------------------------------------------------------------
// mux_n1_rr_reg_pkg
// Shared definitions for the N:1 registered round-robin multiplexer.
//   mode_e : selection mode carried on mode_in
//            MODE_FIXED - take the channel addressed by sel_in
//            MODE_RR    - take the next valid channel after the last grant
// -----------------------------------------------------------------------------
package mux_n1_rr_reg_pkg;

   typedef enum logic {
      MODE_FIXED = 1'b0,
      MODE_RR    = 1'b1
   } mode_e;

endpackage : mux_n1_rr_reg_pkg

// File: rtl/mux_n1_rr_reg_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Rotating-priority finder. Purely combinational.
// The search starts at ptr_i+1 and wraps from CHANNELS-1 to 0. The channel
// at ptr_i itself has the lowest priority.
// Ports:
//   ptr_i   in  SEL_W     last granted channel
//   valid_i in  CHANNELS  per-channel request
//   found_o out 1         at least one request is set
//   index_o out SEL_W     winning channel (0 when found_o=0)
// -----------------------------------------------------------------------------
module rr_pick
#(
   parameter  int CHANNELS = 4,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic [SEL_W-1:0]    ptr_i,
   input  logic [CHANNELS-1:0] valid_i,
   output logic                found_o,
   output logic [SEL_W-1:0]    index_o
);

   logic [SEL_W-1:0] idx;

   // The scan runs from the farthest offset down to the nearest one.
   // The last hit then belongs to the channel closest after ptr_i.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first,
      // so a path that leaves it unassigned cannot infer a latch.
      found_o = 1'b0;
      index_o = '0;
      idx     = '0;
      for (int off = CHANNELS; off >= 1; off--) begin
         idx = SEL_W'((int'(ptr_i) + off) % CHANNELS);
         if (valid_i[idx]) begin
            found_o = 1'b1;
            index_o = idx;
         end
      end
   end

endmodule : rr_pick

// File: rtl/mux_n1_rr_reg.sv
// -----------------------------------------------------------------------------
// mux_n1_rr_reg
// N:1 data multiplexer with a registered output and valid/ready handshakes.
// Each cycle it either takes a fixed channel (sel_in) or the next valid
// channel in round-robin order. The word lands in the output register one
// clock later and is held there while the consumer applies backpressure.
//
// Ports:
//   clk        in   1               rising-edge clock
//   rst        in   1               synchronous, active-high reset
//   data_in    in   CHANNELS*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
//   valid_in   in   CHANNELS        per-channel data valid
//   ready_out  out  CHANNELS        per-channel accept, one-hot or zero
//   mode_in    in   1               0 = FIXED (sel_in), 1 = round-robin
//   sel_in     in   SEL_W           channel index used in FIXED mode
//   y_out      out  WIDTH           registered output data
//   y_valid    out  1               y_out holds a word
//   y_ready    in   1               consumer takes y_out this cycle
//   grant_out  out  SEL_W           channel whose word is in y_out
//   y_parity   out  1               ^y_out, registered with y_out
//                                   (present only with MUX_PARITY_EN)
//
// Build option: define MUX_PARITY_EN to add the y_parity output.
// -----------------------------------------------------------------------------
module mux_n1_rr_reg
   import mux_n1_rr_reg_pkg::*;
#(
   parameter  int WIDTH    = 4,
   parameter  int CHANNELS = 4,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] data_in,
   input  logic [CHANNELS-1:0]       valid_in,
   output logic [CHANNELS-1:0]       ready_out,
   input  logic                      mode_in,
   input  logic [SEL_W-1:0]          sel_in,
   output logic [WIDTH-1:0]          y_out,
   output logic                      y_valid,
   input  logic                      y_ready,
   output logic [SEL_W-1:0]          grant_out
`ifdef MUX_PARITY_EN
   ,
   output logic                      y_parity
`endif
);

   // Output register and arbitration pointer
   logic [WIDTH-1:0] y_q, y_d;
   logic             y_valid_q, y_valid_d;
   logic [SEL_W-1:0] grant_q, grant_d;
   logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
`ifdef MUX_PARITY_EN
   logic             parity_q, parity_d;
`endif

   logic             rr_found;
   logic [SEL_W-1:0] rr_index;
   logic             cand_found;
   logic [SEL_W-1:0] cand_idx;
   logic [WIDTH-1:0] cand_data;
   logic             load_en;
   logic             xfer;

   rr_pick #(
      .CHANNELS (CHANNELS)
   ) u_rr_pick (
      .ptr_i   (rr_ptr_q),
      .valid_i (valid_in),
      .found_o (rr_found),
      .index_o (rr_index)
   );

   // The output register is free when it is empty or is being drained now.
   assign load_en = !y_valid_q || y_ready;

   // Candidate selection. An out-of-range sel_in never selects anything.
   always_comb begin
      cand_found = 1'b0;
      cand_idx   = '0;
      if (mode_e'(mode_in) == MODE_RR) begin
         cand_found = rr_found;
         cand_idx   = rr_index;
      end else if ((int'(sel_in) < CHANNELS) && valid_in[sel_in]) begin
         cand_found = 1'b1;
         cand_idx   = sel_in;
      end
   end

   assign cand_data = data_in[int'(cand_idx)*WIDTH +: WIDTH];

   // No accept is issued during reset, so a producer never loses a word
   // into a register that is being cleared.
   assign xfer = load_en && cand_found && !rst;

   always_comb begin
      ready_out = '0;
      if (xfer) begin
         ready_out[cand_idx] = 1'b1;
      end
   end

   // Next-state logic
   always_comb begin
      y_d       = y_q;
      y_valid_d = y_valid_q;
      grant_d   = grant_q;
      rr_ptr_d  = rr_ptr_q;
`ifdef MUX_PARITY_EN
      parity_d  = parity_q;
`endif
      if (load_en) begin
         if (cand_found) begin
            y_d       = cand_data;
            y_valid_d = 1'b1;
            grant_d   = cand_idx;
            // The pointer follows grants in both modes. A later switch to
            // round-robin then resumes after the last granted channel.
            rr_ptr_d  = cand_idx;
`ifdef MUX_PARITY_EN
            parity_d  = ^cand_data;
`endif
         end else begin
            // The old word, if any, was consumed and nothing replaces it.
            // Data and grant keep their last values.
            y_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments. Every flop then
      // samples its pre-edge value, however the blocks are ordered.
      if (rst) begin
         y_q       <= '0;
         y_valid_q <= 1'b0;
         grant_q   <= '0;
         rr_ptr_q  <= SEL_W'(CHANNELS - 1);
`ifdef MUX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         y_q       <= y_d;
         y_valid_q <= y_valid_d;
         grant_q   <= grant_d;
         rr_ptr_q  <= rr_ptr_d;
`ifdef MUX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign y_out     = y_q;
   assign y_valid   = y_valid_q;
   assign grant_out = grant_q;
`ifdef MUX_PARITY_EN
   assign y_parity  = parity_q;
`endif

endmodule : mux_n1_rr_reg
